pilha_ctrl: RTL
===============

Name: pilha_ctrl

Overview:
- Sequencer for the processor's return-address stack (registered top-of-stack, push/pop strobes).
- Arbitrates between CALL, RET/RETI and interrupt entry; tracks stack depth; issues push/pop to the stack; produces the PC redirect for the fetch unit.
- Sits between the instruction decoder/interrupt line and the stack instance.

Parameters:
- LARGURA, 11, PC/return-address width in bits.
- PROFUNDIDADE, 7, log2 of stack entries (capacity 2^PROFUNDIDADE = 128).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; also drives the stack's reset
- call_req  in  1  single-cycle CALL request from decoder
- call_target  in  LARGURA  CALL destination address
- ret_addr  in  LARGURA  return address (PC+1) to push for CALL/IRQ
- ret_req  in  1  single-cycle RET request
- reti  in  1  qualifies ret_req as return-from-interrupt
- irq_req  in  1  level interrupt request
- irq_vector  in  LARGURA  interrupt handler address
- stk_push  out  1  push strobe to stack
- stk_pop  out  1  pop strobe to stack
- stk_dado  out  LARGURA  data to push
- stk_topo  in  LARGURA  stack top; valid the cycle after stk_pop
- pc_load  out  1  one-cycle PC redirect strobe
- pc_value  out  LARGURA  redirect address, valid while pc_load=1
- busy  out  1  controller not in IDLE
- irq_ack  out  1  one-cycle interrupt acknowledge
- in_isr  out  1  interrupt handler active; masks irq_req
- depth  out  PROFUNDIDADE+1  current entry count, 0..2^PROFUNDIDADE
- overflow  out  1  sticky: push attempted at full
- underflow  out  1  sticky: pop attempted at empty

Behaviour:
- Reset (synchronous): state=IDLE, depth=0, in_isr=0, overflow=0, underflow=0. Outputs pc_load, stk_push, stk_pop, irq_ack are 0. pc_value and stk_dado are 0.
- States: IDLE, PUSH, POP, WAIT, LOAD. busy=1 in every state except IDLE.
- Arbitration in IDLE, sampled at the clock edge, fixed priority:
  - irq_req and !in_isr
  - ret_req
  - call_req
- Requests arriving while busy=1 are dropped. The decoder guarantees no issue while busy.
- A lower-priority request that coincides with an accepted one is dropped.
- CALL/IRQ when depth < 2^PROFUNDIDADE:
  - IDLE→PUSH: latch ret_addr into stk_dado; latch target = call_target or irq_vector.
  - PUSH (1 cycle): stk_push=1, depth+1; irq_ack=1 for an IRQ.
  - LOAD (1 cycle): pc_load=1, pc_value=target; IRQ sets in_isr at the end of LOAD.
  - Then IDLE. Latency from accept edge: push in cycle +1, pc_load in cycle +2.
- CALL/IRQ when depth == 2^PROFUNDIDADE: overflow←1, stay IDLE, no push, no pc_load, no irq_ack, depth unchanged.
- RET when depth > 0:
  - IDLE→POP: stk_pop=1 for one cycle, depth−1.
  - WAIT: capture stk_topo into pc_value at the end of the cycle.
  - LOAD: pc_load=1; if reti was latched at accept, in_isr←0 at the end of LOAD.
  - Then IDLE. pc_load occurs in cycle +3 from the accept edge.
- RET when depth == 0: underflow←1, stay IDLE, no pop, in_isr unchanged.
- stk_push and stk_pop are never asserted together and never asserted outside PUSH/POP.
- depth never wraps. overflow and underflow clear only on reset.
- reset asserted in any state overrides everything. An in-flight operation is abandoned: no pc_load in the following cycle.

Test Plan:
- Reset, then CALL ret_addr=0x010, call_target=0x200 → cycle+1: stk_push=1, stk_dado=0x010, depth=1; cycle+2: pc_load=1, pc_value=0x200; busy high for exactly 2 cycles.
- After that CALL, RET with stk_topo=0x010 after pop → stk_pop=1 one cycle, depth=0, pc_load=1 with pc_value=0x010 at cycle+3.
- irq_req, ret_req and call_req in the same IDLE cycle, irq_vector=0x7F0, depth=0 → IRQ wins: irq_ack=1, push, pc_value=0x7F0, in_isr=1. With irq_req still high, next RET(reti=1) pops and clears in_isr; a second IRQ is then accepted.
- 128 CALLs → depth=128; 129th CALL → overflow=1, no stk_push, no pc_load, depth stays 128.
- RET at depth=0 → underflow=1, no stk_pop, no pc_load; a later valid CALL still works and the flag stays 1.
- reset asserted during WAIT of a RET → next cycle state IDLE, depth=0, no pc_load, in_isr=0, flags 0.

Source files
------------

// File: rtl/pilha_ctrl_if.sv
// pilha_ctrl_if
// Groups the signals that run between the return-stack sequencer, the
// decoder/interrupt line, the stack instance and the fetch unit.
//   call_req/call_target/ret_addr  CALL request, destination and return address
//   ret_req/reti                   RET request, qualified as RETI when reti=1
//   irq_req/irq_vector             level interrupt request and handler address
//   stk_push/stk_pop/stk_dado      strobes and push data towards the stack
//   stk_topo                       stack top, valid the cycle after a pop
//   pc_load/pc_value               one-cycle PC redirect to the fetch unit
//   busy/irq_ack/in_isr            controller status
//   depth/overflow/underflow       entry count and sticky error flags
// slave is the sequencer's view, master is the surrounding logic's view.
interface pilha_ctrl_if #(
  parameter int LARGURA      = 11,
  parameter int PROFUNDIDADE = 7
);
  logic                  call_req;
  logic [LARGURA-1:0]    call_target;
  logic [LARGURA-1:0]    ret_addr;
  logic                  ret_req;
  logic                  reti;
  logic                  irq_req;
  logic [LARGURA-1:0]    irq_vector;
  logic                  stk_push;
  logic                  stk_pop;
  logic [LARGURA-1:0]    stk_dado;
  logic [LARGURA-1:0]    stk_topo;
  logic                  pc_load;
  logic [LARGURA-1:0]    pc_value;
  logic                  busy;
  logic                  irq_ack;
  logic                  in_isr;
  logic [PROFUNDIDADE:0] depth;
  logic                  overflow;
  logic                  underflow;

  modport slave (
    input  call_req, call_target, ret_addr, ret_req, reti,
           irq_req, irq_vector, stk_topo,
    output stk_push, stk_pop, stk_dado, pc_load, pc_value,
           busy, irq_ack, in_isr, depth, overflow, underflow
  );

  modport master (
    output call_req, call_target, ret_addr, ret_req, reti,
           irq_req, irq_vector, stk_topo,
    input  stk_push, stk_pop, stk_dado, pc_load, pc_value,
           busy, irq_ack, in_isr, depth, overflow, underflow
  );
endinterface

// File: rtl/pilha_ctrl.sv
// pilha_ctrl
// Sequencer for the return-address stack. Arbitrates between interrupt
// entry, RET/RETI and CALL (in that priority), keeps track of the stack
// depth, issues push/pop strobes to the stack and produces the PC redirect.
//   clk    clock
//   reset  synchronous, active-high; also intended to reset the stack
//   bus    pilha_ctrl_if.slave carrying requests, stack and fetch signals
module pilha_ctrl #(
  parameter int LARGURA      = 11,
  parameter int PROFUNDIDADE = 7
) (
  input  logic        clk,
  input  logic        reset,
  pilha_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PUSH, POP, WAIT, LOAD} estado_t;

  localparam logic [PROFUNDIDADE:0] CHEIO = {1'b1, {PROFUNDIDADE{1'b0}}};
  localparam logic [PROFUNDIDADE:0] UM    = {{PROFUNDIDADE{1'b0}}, 1'b1};

  estado_t            state;
  logic [LARGURA-1:0] target;
  logic               op_irq;
  logic               op_reti;

  assign bus.busy = (state != IDLE);

  // Single FSM with all strobes registered. Strobes default low each cycle so
  // every strobe lasts exactly one cycle. A push/pop is launched on the accept
  // edge so the strobe and the new depth appear together in the next cycle.
  // For a RET, the stack presents the popped value during WAIT and it is
  // captured into pc_value at the end of WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      target        <= '0;
      op_irq        <= 1'b0;
      op_reti       <= 1'b0;
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.stk_dado  <= '0;
      bus.pc_load   <= 1'b0;
      bus.pc_value  <= '0;
      bus.irq_ack   <= 1'b0;
      bus.in_isr    <= 1'b0;
      bus.depth     <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.stk_push <= 1'b0;
      bus.stk_pop  <= 1'b0;
      bus.pc_load  <= 1'b0;
      bus.irq_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.irq_req && !bus.in_isr) begin
            if (bus.depth == CHEIO) begin
              bus.overflow <= 1'b1;
            end else begin
              bus.stk_dado <= bus.ret_addr;
              target       <= bus.irq_vector;
              op_irq       <= 1'b1;
              op_reti      <= 1'b0;
              bus.stk_push <= 1'b1;
              bus.irq_ack  <= 1'b1;
              bus.depth    <= bus.depth + UM;
              state        <= PUSH;
            end
          end else if (bus.ret_req) begin
            if (bus.depth == '0) begin
              bus.underflow <= 1'b1;
            end else begin
              op_irq      <= 1'b0;
              op_reti     <= bus.reti;
              bus.stk_pop <= 1'b1;
              bus.depth   <= bus.depth - UM;
              state       <= POP;
            end
          end else if (bus.call_req) begin
            if (bus.depth == CHEIO) begin
              bus.overflow <= 1'b1;
            end else begin
              bus.stk_dado <= bus.ret_addr;
              target       <= bus.call_target;
              op_irq       <= 1'b0;
              op_reti      <= 1'b0;
              bus.stk_push <= 1'b1;
              bus.depth    <= bus.depth + UM;
              state        <= PUSH;
            end
          end
        end
        PUSH: begin
          bus.pc_load  <= 1'b1;
          bus.pc_value <= target;
          state        <= LOAD;
        end
        POP: begin
          state <= WAIT;
        end
        WAIT: begin
          bus.pc_load  <= 1'b1;
          bus.pc_value <= bus.stk_topo;
          state        <= LOAD;
        end
        LOAD: begin
          // Handler state changes only once the redirect has been issued.
          if (op_irq)  bus.in_isr <= 1'b1;
          if (op_reti) bus.in_isr <= 1'b0;
          op_irq  <= 1'b0;
          op_reti <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
